// File: rtl/fifo_sync_prog_if.sv
// Handshake bundle between the producer/consumer pipelines and fifo_sync_prog.
// master drives requests and thresholds, slave returns data, flags and status.
interface fifo_sync_prog_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CW         = 5
);
   logic                  flush;
   logic [DATA_WIDTH-1:0] din;
   logic                  wr_en;
   logic                  rd_en;
   logic [CW-1:0]         prog_full_thresh;
   logic [CW-1:0]         prog_empty_thresh;
   logic [DATA_WIDTH-1:0] dout;
   logic                  data_valid;
   logic                  full;
   logic                  almost_full;
   logic                  prog_full;
   logic                  empty;
   logic                  almost_empty;
   logic                  prog_empty;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic [CW-1:0]         data_count;
   logic [CW-1:0]         peak_count;

   modport master (
      output flush, din, wr_en, rd_en,
      output prog_full_thresh, prog_empty_thresh,
      input  dout, data_valid,
      input  full, almost_full, prog_full,
      input  empty, almost_empty, prog_empty,
      input  wr_ack, overflow, underflow,
      input  data_count, peak_count
   );

   modport slave (
      input  flush, din, wr_en, rd_en,
      input  prog_full_thresh, prog_empty_thresh,
      output dout, data_valid,
      output full, almost_full, prog_full,
      output empty, almost_empty, prog_empty,
      output wr_ack, overflow, underflow,
      output data_count, peak_count
   );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable thresholds, synchronous flush,
// peak-occupancy monitor and selectable standard / FWFT read mode.
module fifo_sync_prog #(
   parameter int                    FIFO_WRITE_DEPTH = 16,
   parameter int                    DATA_WIDTH       = 32,
   parameter bit                    READ_MODE_FWFT   = 1'b0,
   parameter logic [DATA_WIDTH-1:0] DOUT_RESET_VALUE = '0
) (
   input logic             wr_clk,
   input logic             rst_n,
   fifo_sync_prog_if.slave bus
);
   localparam int AW = $clog2(FIFO_WRITE_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_WRITE_DEPTH);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [DATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];

   logic [CW-1:0]         wr_ptr;
   logic [CW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nxt;
   logic [CW-1:0]         peak;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  valid_q;
   logic                  wr_ack_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  full;
   logic                  empty;
   logic                  wr_acc;
   logic                  rd_acc;

   // Pointers carry one extra wrap bit so full and empty stay distinct.
   assign count = wr_ptr - rd_ptr;
   assign full  = (count == DEPTH);
   assign empty = (count == '0);

   assign wr_acc = bus.wr_en && !full && !bus.flush;
   assign rd_acc = bus.rd_en && !empty && !bus.flush;

   always_comb begin
      count_nxt = count;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + ONE;
         2'b01:   count_nxt = count - ONE;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (wr_acc) begin
         mem[wr_ptr[AW-1:0]] <= bus.din;
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         peak        <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         valid_q     <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         peak        <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr + {{(CW-1){1'b0}}, wr_acc};
         rd_ptr      <= rd_ptr + {{(CW-1){1'b0}}, rd_acc};
         peak        <= (count_nxt > peak) ? count_nxt : peak;
         wr_ack_q    <= wr_acc;
         overflow_q  <= bus.wr_en && full;
         underflow_q <= bus.rd_en && empty;
         valid_q     <= rd_acc;
      end
   end

   // Holds the last word read; in FWFT it is only visible while empty.
   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= DOUT_RESET_VALUE;
      end else if (rd_acc) begin
         dout_q <= mem[rd_ptr[AW-1:0]];
      end
   end

   assign bus.dout = (READ_MODE_FWFT && !empty) ?
                     mem[rd_ptr[AW-1:0]] : dout_q;
   assign bus.data_valid = READ_MODE_FWFT ? !empty : valid_q;

   assign bus.full         = full;
   assign bus.almost_full  = (count >= DEPTH - ONE);
   assign bus.prog_full    = (count >= bus.prog_full_thresh);
   assign bus.empty        = empty;
   assign bus.almost_empty = (count <= ONE);
   assign bus.prog_empty   = (count <= bus.prog_empty_thresh);
   assign bus.wr_ack       = wr_ack_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
   assign bus.data_count   = count;
   assign bus.peak_count   = peak;
endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: std and FWFT instances share one stimulus
// stream and are checked against a queue-based reference model.
module tb_fifo_sync_prog;
   localparam int DEPTH = 16;
   localparam int DW    = 32;
   localparam int CW    = 5;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [DW-1:0] din;
   logic          wr_en;
   logic          rd_en;
   logic [CW-1:0] pf_th;
   logic [CW-1:0] pe_th;

   int n_chk;
   int n_err;

   logic [DW-1:0] q[$];
   int            peak;
   logic [DW-1:0] e_sdout;
   logic          e_sv;
   logic          e_ack;
   logic          e_ov;
   logic          e_un;

   fifo_sync_prog_if #(.DATA_WIDTH(DW), .CW(CW)) if_s ();
   fifo_sync_prog_if #(.DATA_WIDTH(DW), .CW(CW)) if_f ();

   assign if_s.flush = flush;
   assign if_s.din = din;
   assign if_s.wr_en = wr_en;
   assign if_s.rd_en = rd_en;
   assign if_s.prog_full_thresh = pf_th;
   assign if_s.prog_empty_thresh = pe_th;
   assign if_f.flush = flush;
   assign if_f.din = din;
   assign if_f.wr_en = wr_en;
   assign if_f.rd_en = rd_en;
   assign if_f.prog_full_thresh = pf_th;
   assign if_f.prog_empty_thresh = pe_th;

   fifo_sync_prog #(
      .FIFO_WRITE_DEPTH(DEPTH),
      .DATA_WIDTH(DW),
      .READ_MODE_FWFT(1'b0),
      .DOUT_RESET_VALUE('0)
   ) u_std (
      .wr_clk(clk),
      .rst_n(rst_n),
      .bus(if_s)
   );

   fifo_sync_prog #(
      .FIFO_WRITE_DEPTH(DEPTH),
      .DATA_WIDTH(DW),
      .READ_MODE_FWFT(1'b1),
      .DOUT_RESET_VALUE('0)
   ) u_fwft (
      .wr_clk(clk),
      .rst_n(rst_n),
      .bus(if_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      peak = 0;
      e_sdout = '0;
      e_sv = 1'b0;
      e_ack = 1'b0;
      e_ov = 1'b0;
      e_un = 1'b0;
   endtask

   task automatic check_all();
      int sz;
      logic [9:0] ef_s;
      logic [9:0] ef_f;
      sz = q.size();
      ef_s = {sz == DEPTH, sz >= DEPTH - 1, sz >= int'(pf_th),
              sz == 0, sz <= 1, sz <= int'(pe_th),
              e_ack, e_ov, e_un, e_sv};
      ef_f = {ef_s[9:1], sz != 0};
      chk("flags_std",
          {if_s.full, if_s.almost_full, if_s.prog_full,
           if_s.empty, if_s.almost_empty, if_s.prog_empty,
           if_s.wr_ack, if_s.overflow, if_s.underflow,
           if_s.data_valid}, ef_s);
      chk("flags_fwft",
          {if_f.full, if_f.almost_full, if_f.prog_full,
           if_f.empty, if_f.almost_empty, if_f.prog_empty,
           if_f.wr_ack, if_f.overflow, if_f.underflow,
           if_f.data_valid}, ef_f);
      chk("count_std", if_s.data_count, sz);
      chk("count_fwft", if_f.data_count, sz);
      chk("peak_std", if_s.peak_count, peak);
      chk("peak_fwft", if_f.peak_count, peak);
      chk("dout_std", if_s.dout, e_sdout);
      if (sz != 0) chk("dout_fwft", if_f.dout, q[0]);
   endtask

   // Reference: queue of stored words, decisions from pre-edge occupancy.
   task automatic step(input logic w, input logic r, input logic fl,
                       input logic [DW-1:0] d);
      bit was_full;
      bit was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (fl) begin
         q.delete();
         peak = 0;
         e_sv = 1'b0;
         e_ack = 1'b0;
         e_ov = 1'b0;
         e_un = 1'b0;
      end else begin
         e_sv = r && !was_empty;
         if (e_sv) e_sdout = q.pop_front();
         e_ack = w && !was_full;
         if (e_ack) q.push_back(d);
         e_ov = w && was_full;
         e_un = r && was_empty;
         if (q.size() > peak) peak = q.size();
      end
      wr_en = w;
      rd_en = r;
      flush = fl;
      din = d;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wr(input logic [DW-1:0] d);
      step(1'b1, 1'b0, 1'b0, d);
   endtask

   task automatic rd();
      step(1'b0, 1'b1, 1'b0, $urandom);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      din = '0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      pf_th = 5'd16;
      pe_th = 5'd0;
      model_reset();
      #12;
      check_all();
      chk("rst_dout_fwft", if_f.dout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) wr(i);
      wr(32'hdead_beef);
      idle();

      for (int i = 0; i < DEPTH; i++) rd();
      rd();
      idle();

      wr(32'h0000_00a5);
      idle();

      for (int i = 0; i < DEPTH - 1; i++) wr($urandom);
      step(1'b1, 1'b1, 1'b0, 32'h1111_1111);
      while (q.size() != 0) rd();
      step(1'b1, 1'b1, 1'b0, 32'h2222_2222);
      idle();

      step(1'b0, 1'b0, 1'b1, '0);
      pf_th = 5'd10;
      pe_th = 5'd3;
      for (int i = 0; i < 10; i++) wr($urandom);
      pf_th = 5'd12;
      #1;
      check_all();
      pf_th = 5'd10;
      #1;
      check_all();
      for (int i = 0; i < 7; i++) rd();
      pf_th = 5'd0;
      pe_th = 5'd16;
      #1;
      check_all();

      step(1'b0, 1'b0, 1'b1, '0);
      pf_th = 5'd12;
      pe_th = 5'd4;
      for (int i = 0; i < 8; i++) wr($urandom);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, 1'b0, $urandom);
         step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0,
              $urandom);
      end
      while (q.size() < 9) wr($urandom);
      while (q.size() > 9) rd();
      step(1'b1, 1'b0, 1'b1, 32'h3333_3333);
      idle();

      for (int i = 0; i < 30; i++)
         step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0,
              $urandom);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_mid_dout_fwft", if_f.dout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wr(32'h4444_4444);
      idle();

      for (int i = 0; i < 150; i++) begin
         pf_th = 5'($urandom_range(17));
         pe_th = 5'($urandom_range(17));
         step(1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
              1'($urandom_range(40) == 0), $urandom);
      end
      while (q.size() != 0) rd();
      rd();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
